axi_cfg_slice: RTL and testbench
================================

// Module: axi_cfg_slice
// PURPOSE
//  Generic valid/ready pipeline slice for one AXI channel (AW/W/B/AR/R).
//  A single MODE parameter selects the slice type: pass-through, forward register,
//  full skid buffer, or a DEPTH-entry FIFO with fill level and flush.
//  Placed at crossbar and port boundaries to break timing paths.
//  Storage is local; the generic fifo is not instantiated.
// PARAMETERS
//  MODE        axi_slice_pkg::SLICE_SKID  slice type: SLICE_PASS/SLICE_FWD/SLICE_SKID/SLICE_FIFO
//  DATA_WIDTH  64                         payload width in bits, >=1
//  DEPTH       4                          entries in SLICE_FIFO only; power of 2, >=2
//  CNT_W       $clog2(DEPTH+1)            derived, width of usage_o (localparam, not overridable)
// PORTS
//  clk_i       in   1           clock
//  rst_ni      in   1           asynchronous reset, active low
//  testmode_i  in   1           DFT mode; no functional effect
//  flush_i     in   1           synchronous discard of all stored beats
//  valid_i     in   1           upstream beat valid
//  ready_o     out  1           upstream ready
//  data_i      in   DATA_WIDTH  upstream payload
//  valid_o     out  1           downstream beat valid
//  ready_i     in   1           downstream ready
//  data_o      out  DATA_WIDTH  downstream payload
//  usage_o     out  CNT_W       number of stored beats
// BEHAVIOUR
//  Transfer: a beat moves when valid & ready are both high at a clk_i rising edge.
//  Once valid_o=1, valid_o and data_o stay stable until a handshake (AXI rule).
//  Reset, all register modes: valid_o=0, ready_o=1, usage_o=0, data_o='0.
//    Pointers and storage are cleared. Reset mid-burst drops all stored beats.
//  SLICE_PASS: pure wires (valid_o=valid_i, ready_o=ready_i, data_o=data_i).
//    usage_o=0. flush_i ignored. Zero latency.
//  SLICE_FWD: one register for valid and data; latency 1 cycle.
//    ready_o = ~valid_o | ready_i (a combinational ready path is allowed).
//    Full throughput of 1 beat per cycle. usage_o is 0..1.
//  SLICE_SKID: main register plus skid register.
//    ready_o is driven directly from a flop (= skid register empty).
//    No combinational path in either direction. Latency 1 cycle, 1 beat per cycle.
//    When ready_i drops while a beat is accepted, that beat goes into the skid register.
//    The next cycle ready_o=0. The skid beat drains before any new beat.
//    usage_o is 0..2.
//  SLICE_FIFO: DEPTH-entry circular buffer.
//    ready_o=~full, valid_o=~empty, latency 1 cycle (no fall-through).
//    Full: a push is refused even if a pop happens the same cycle.
//      ready_o rises the cycle after the pop.
//    Simultaneous push and pop while partly full: usage is unchanged and both pointers advance.
//    Pointers wrap modulo DEPTH. usage_o saturates at DEPTH and never exceeds it.
//  Flush (all register modes):
//    Next cycle: valid_o=0, usage_o=0, ready_o=1.
//    An input accepted in the flush cycle is discarded.
//    An output handshake in the flush cycle still completes.
//  Order is strictly FIFO; no beat is duplicated or dropped except by flush or reset.
//  Elaboration assertions: DATA_WIDTH>=1; DEPTH a power of 2 and >=2 when MODE=SLICE_FIFO.
// STRUCTURE
//  axi_slice_pkg holds:
//    typedef enum logic [1:0] slice_mode_e {SLICE_PASS, SLICE_FWD, SLICE_SKID, SLICE_FIFO}
//    localparam SKID_DEPTH=2
//  One generate-if per mode, each in a single module.
//  No sub-module: the FIFO branch is a counter and pointer pair.
// TESTING
//  1 Per mode: reset, then 16 beats (data=i) with ready_i=1.
//    Required: data_o sequence 0..15; latency 0/1/1/1 cycles for PASS/FWD/SKID/FIFO.
//  2 SKID: stream with ready_i toggling 1,0,1,0.
//    Required: no loss; ready_o=0 only while the skid register is full;
//    ready_o never depends combinationally on ready_i.
//  3 FIFO DEPTH=4: push 4 with ready_i=0.
//    Required: usage_o=4 and ready_o=0. A 5th valid_i is not accepted.
//    Then pop and push in the same cycle: the push is refused; the next cycle ready_o=1, usage_o=3.
//  4 FIFO: 100 random push/pop cycles.
//    Required: output matches the scoreboard; usage_o equals the model each cycle; pointers wrap correctly.
//  5 Flush with usage_o=3 while valid_i=1.
//    Required: the next cycle usage_o=0 and valid_o=0, and the pushed beat never appears.
//  6 Assert rst_ni asynchronously with usage_o=2.
//    Required: valid_o=0 and usage_o=0 immediately, ready_o=1 after release.

Source files
------------

// File: rtl/axi_slice_pkg.sv
// Shared types and constants for the configurable AXI channel slice.
package axi_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_PASS,
        SLICE_FWD,
        SLICE_SKID,
        SLICE_FIFO
    } slice_mode_e;

    // Storage slots of the skid slice: main register plus skid register.
    localparam int unsigned SKID_DEPTH = 2;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_cfg_slice.sv
// Valid/ready pipeline slice for one AXI channel. MODE selects wires,
// a forward register, a full skid buffer or a small circular FIFO.
module axi_cfg_slice
    import axi_slice_pkg::*;
#(
    parameter slice_mode_e MODE       = SLICE_SKID,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  testmode_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      usage_o
);

    // DFT mode has no functional effect on the slice.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    if (DATA_WIDTH < 1) begin : g_chk_width
        $error("axi_cfg_slice: DATA_WIDTH must be >= 1");
    end

    if ((MODE == SLICE_FIFO) && ((DEPTH < 2) || !is_pow2(DEPTH))) begin : g_chk_depth
        $error("axi_cfg_slice: DEPTH must be a power of 2 and >= 2 in FIFO mode");
    end

    if (MODE == SLICE_PASS) begin : g_pass

        // Pure wiring: clock, reset and flush have nothing to act on.
        logic unused_pass;
        assign unused_pass = ^{clk_i, rst_ni, flush_i};

        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;

    end else if (MODE == SLICE_FWD) begin : g_fwd

        logic                  valid_q, valid_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;

        // Register may load whenever it is empty or being drained this cycle.
        assign ready_o = ~valid_q | ready_i;

        // Next state of the forward register.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (ready_o) begin
                valid_d = valid_i;
                if (valid_i) begin
                    data_d = data_i;
                end
            end
            if (flush_i) begin
                valid_d = 1'b0;
            end
        end

        // Forward register state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign valid_o = valid_q;
        assign data_o  = data_q;
        assign usage_o = CNT_W'(valid_q);

    end else if (MODE == SLICE_SKID) begin : g_skid

        logic                  valid_q, valid_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  skid_valid_q, skid_valid_d;
        logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
        logic                  rdy_q, rdy_d;

        // Main/skid next state. A held skid beat always drains into main first,
        // and a beat arriving while main stalls is parked in the skid register.
        always_comb begin
            valid_d      = valid_q;
            data_d       = data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (skid_valid_q) begin
                if (ready_i) begin
                    valid_d      = 1'b1;
                    data_d       = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end else if (!valid_q || ready_i) begin
                valid_d = valid_i;
                if (valid_i) begin
                    data_d = data_i;
                end
            end else if (valid_i) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_i;
            end
            if (flush_i) begin
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
            end
            rdy_d = ~skid_valid_d;
        end

        // Main, skid and ready flops; ready_o comes straight from rdy_q.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q      <= 1'b0;
                data_q       <= '0;
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
                rdy_q        <= 1'b1;
            end else begin
                valid_q      <= valid_d;
                data_q       <= data_d;
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
                rdy_q        <= rdy_d;
            end
        end

        assign ready_o = rdy_q;
        assign valid_o = valid_q;
        assign data_o  = data_q;
        assign usage_o = CNT_W'(valid_q) + CNT_W'(skid_valid_q);

    end else begin : g_fifo

        localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  full, empty, push, pop;

        // A full FIFO refuses a push even when a pop happens in the same cycle.
        assign full  = (cnt_q == CNT_W'(DEPTH));
        assign empty = (cnt_q == '0);
        assign push  = valid_i & ~full;
        assign pop   = ready_i & ~empty;

        // Pointer and fill-level next state; DEPTH is a power of 2 so the
        // pointers wrap by natural overflow.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end
        end

        // Pointer and counter state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage write; a beat pushed during a flush is discarded.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end

        assign ready_o = ~full;
        assign valid_o = ~empty;
        assign data_o  = mem_q[rd_ptr_q];
        assign usage_o = cnt_q;

    end

endmodule

// File: tb/tb_axi_cfg_slice.sv
// Bench for axi_cfg_slice: one instance per mode sharing the same stimulus,
// checked every cycle against per-mode queue models plus literal expectations.
module tb_axi_cfg_slice;
    import axi_slice_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;

    logic          vo [4];
    logic          ro [4];
    logic [DW-1:0] dout [4];
    logic [CW-1:0] uo [4];

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    // Expected contents of each stored-beat slice.
    logic [DW-1:0] qf[$];
    logic [DW-1:0] qs[$];
    logic [DW-1:0] qo[$];

    always #5 clk = ~clk;

    axi_cfg_slice #(.MODE(SLICE_PASS), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ro[0]), .data_i(data_i),
        .valid_o(vo[0]), .ready_i(ready_i), .data_o(dout[0]), .usage_o(uo[0]));

    axi_cfg_slice #(.MODE(SLICE_FWD), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_fwd (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ro[1]), .data_i(data_i),
        .valid_o(vo[1]), .ready_i(ready_i), .data_o(dout[1]), .usage_o(uo[1]));

    axi_cfg_slice #(.MODE(SLICE_SKID), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_skid (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ro[2]), .data_i(data_i),
        .valid_o(vo[2]), .ready_i(ready_i), .data_o(dout[2]), .usage_o(uo[2]));

    axi_cfg_slice #(.MODE(SLICE_FIFO), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ro[3]), .data_i(data_i),
        .valid_o(vo[3]), .ready_i(ready_i), .data_o(dout[3]), .usage_o(uo[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a slice is a queue of accepted beats with a capacity; the head is
    // what must be presented downstream. FWD may also accept when being drained.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qf.delete();
            qs.delete();
            qo.delete();
        end else begin
            bit acc, deq;
            acc = valid_i && ((qf.size() == 0) || ready_i);
            deq = (qf.size() > 0) && ready_i;
            if (deq) void'(qf.pop_front());
            if (acc) qf.push_back(data_i);
            if (flush) qf.delete();

            acc = valid_i && (qs.size() < SKID_DEPTH);
            deq = (qs.size() > 0) && ready_i;
            if (deq) void'(qs.pop_front());
            if (acc) qs.push_back(data_i);
            if (flush) qs.delete();

            acc = valid_i && (qo.size() < DEPTH);
            deq = (qo.size() > 0) && ready_i;
            if (deq) void'(qo.pop_front());
            if (acc) qo.push_back(data_i);
            if (flush) qo.delete();
        end
    end

    task automatic cmp_q(input string tag, input int idx, input int n,
                         input logic [DW-1:0] head, input logic exp_rdy);
        chk({tag, "_valid"}, vo[idx], n > 0);
        chk({tag, "_ready"}, ro[idx], exp_rdy);
        chk({tag, "_usage"}, uo[idx], n);
        if (n > 0) chk({tag, "_data"}, dout[idx], head);
    endtask

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("pass_valid", vo[0], valid_i);
            chk("pass_ready", ro[0], ready_i);
            chk("pass_data", dout[0], data_i);
            chk("pass_usage", uo[0], 0);
            cmp_q("fwd", 1, qf.size(), (qf.size() > 0) ? qf[0] : '0,
                  (qf.size() == 0) || ready_i);
            cmp_q("skid", 2, qs.size(), (qs.size() > 0) ? qs[0] : '0,
                  qs.size() < SKID_DEPTH);
            cmp_q("fifo", 3, qo.size(), (qo.size() > 0) ? qo[0] : '0,
                  qo.size() < DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush   = f;
    endtask

    task automatic drain(input int n);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        run_cmp = 1'b1;
        // Reset state.
        repeat (2) tick();
        for (int m = 1; m < 4; m++) begin
            chk("rst_valid", vo[m], 1'b0);
            chk("rst_ready", ro[m], 1'b1);
            chk("rst_usage", uo[m], 0);
            chk("rst_data", dout[m], 0);
        end
        rst_n = 1'b1;
        tick();

        // 1: 16 beats, data=i, ready_i=1.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            #1;
            chk("lat0_pass_data", dout[0], i);
            tick();
            chk("lat1_fwd_data", dout[1], i);
            chk("lat1_skid_data", dout[2], i);
            chk("lat1_fifo_data", dout[3], i);
            chk("lat1_fifo_valid", vo[3], 1'b1);
        end
        drain(4);

        // 2: skid stream with ready_i toggling.
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, DW'(100 + k), (k % 2) == 0, 1'b0);
            tick();
            if (k == 1) begin
                chk("skid_full_ready", ro[2], 1'b0);
                chk("skid_full_usage", uo[2], 2);
                chk("skid_full_data", dout[2], 100);
            end
            if (k == 2) begin
                chk("skid_drain_ready", ro[2], 1'b1);
                chk("skid_drain_data", dout[2], 101);
            end
            if (k == 3) begin
                ready_i = 1'b1;
                #1 chk("skid_noncomb_r1", ro[2], 1'b0);
                ready_i = 1'b0;
                #1 chk("skid_noncomb_r0", ro[2], 1'b0);
            end
        end
        drain(8);

        // 3: FIFO fill, refused 5th beat, pop+push while full.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, DW'(200 + k), 1'b0, 1'b0);
            tick();
            if (k >= 3) begin
                chk("fifo_full_usage", uo[3], 4);
                chk("fifo_full_ready", ro[3], 1'b0);
                chk("fifo_full_head", dout[3], 200);
            end
        end
        drive(1'b1, DW'(205), 1'b1, 1'b0);
        tick();
        chk("fifo_poppush_usage", uo[3], 3);
        chk("fifo_poppush_ready", ro[3], 1'b1);
        chk("fifo_poppush_head", dout[3], 201);
        drain(8);

        // 4: random push/pop.
        for (int k = 0; k < 100; k++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        drain(8);

        // 5: flush with usage 3 while valid_i=1.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DW'(300 + k), 1'b0, 1'b0);
            tick();
        end
        chk("flush_pre_usage", uo[3], 3);
        drive(1'b1, DW'(303), 1'b0, 1'b1);
        tick();
        chk("flush_usage", uo[3], 0);
        chk("flush_valid", vo[3], 1'b0);
        chk("flush_ready", ro[3], 1'b1);
        chk("flush_skid_usage", uo[2], 0);
        chk("flush_fwd_valid", vo[1], 1'b0);
        drain(3);
        chk("flush_no_ghost", vo[3], 1'b0);

        // 6: asynchronous reset with usage 2.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, DW'(400 + k), 1'b0, 1'b0);
            tick();
        end
        chk("arst_pre_usage", uo[3], 2);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fifo_valid", vo[3], 1'b0);
        chk("arst_fifo_usage", uo[3], 0);
        chk("arst_skid_valid", vo[2], 1'b0);
        chk("arst_fwd_valid", vo[1], 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("arst_fifo_ready", ro[3], 1'b1);
        chk("arst_skid_ready", ro[2], 1'b1);
        chk("arst_skid_usage", uo[2], 0);
        drain(2);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
